// File: rtl/dm_result_checker_if.sv
// Bus bundle for the end-of-test result checker: DM write snoop, the two
// read ports (DM result region and golden store) and the status outputs.
interface dm_result_checker_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int NUM_W  = 7,
    parameter int CYC_W  = 32
);
    logic [DATA_W/8-1:0] snoop_we;
    logic [ADDR_W-1:0]   snoop_addr;
    logic [DATA_W-1:0]   snoop_wdata;
    logic [NUM_W-1:0]    golden_num;
    logic                dm_req;
    logic [ADDR_W-1:0]   dm_addr;
    logic [DATA_W-1:0]   dm_rdata;
    logic                gold_req;
    logic [NUM_W-1:0]    gold_addr;
    logic [DATA_W-1:0]   gold_rdata;
    logic                done;
    logic                pass;
    logic                timeout;
    logic [NUM_W-1:0]    err_cnt;
    logic [NUM_W-1:0]    first_err_idx;
    logic [CYC_W-1:0]    cycle_cnt;

    // Environment side: drives snoop, golden count and read data.
    modport master (
        output snoop_we, snoop_addr, snoop_wdata, golden_num, dm_rdata, gold_rdata,
        input  dm_req, dm_addr, gold_req, gold_addr,
        input  done, pass, timeout, err_cnt, first_err_idx, cycle_cnt
    );

    // Checker side.
    modport slave (
        input  snoop_we, snoop_addr, snoop_wdata, golden_num, dm_rdata, gold_rdata,
        output dm_req, dm_addr, gold_req, gold_addr,
        output done, pass, timeout, err_cnt, first_err_idx, cycle_cnt
    );
endinterface

// File: rtl/dm_result_checker.sv
// End-of-test checker: waits for the end-of-simulation store (or a watchdog),
// then streams the DM result region against golden data and reports a verdict.
module dm_result_checker #(
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] TEST_START = 14'h2000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 14'h3fff,
    parameter logic [DATA_W-1:0] END_CODE   = 32'hFFFF_FFFF,
    parameter int                NUM_W      = 7,
    parameter int                MAX_CYCLES = 100000,
    parameter int                CYC_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    dm_result_checker_if.slave  bus
);
    typedef enum logic [1:0] {S_RUN, S_CHECK, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [NUM_W-1:0]   idx_q, idx_d;
    logic [NUM_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic               dm_req_q, dm_req_d;
    logic [ADDR_W-1:0]  dm_addr_q, dm_addr_d;
    logic [NUM_W-1:0]   gold_addr_q, gold_addr_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic [NUM_W-1:0]   err_cnt_q, err_cnt_d;
    logic [NUM_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;

    logic marker, wd_hit, mismatch, finish;

    // Next-state logic: marker/watchdog detection, read issue, compare, verdict.
    always_comb begin
        state_d         = state_q;
        num_d           = num_q;
        idx_d           = idx_q;
        cmp_idx_d       = idx_q;
        cmp_vld_d       = dm_req_q;
        dm_req_d        = dm_req_q;
        dm_addr_d       = dm_addr_q;
        gold_addr_d     = gold_addr_q;
        done_d          = done_q;
        pass_d          = pass_q;
        timeout_d       = timeout_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        cycle_cnt_d     = cycle_cnt_q;
        finish          = 1'b0;

        marker   = (&bus.snoop_we) && (bus.snoop_addr == END_ADDR) && (bus.snoop_wdata == END_CODE);
        wd_hit   = (cycle_cnt_q == CYC_W'(MAX_CYCLES - 1));
        // Read data for the request issued last cycle is on the ports now.
        mismatch = cmp_vld_q && (bus.dm_rdata != bus.gold_rdata);

        if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            // All-ones can never be a real index, so it doubles as "none yet".
            if (first_err_idx_q == '1) first_err_idx_d = cmp_idx_q;
        end

        case (state_q)
            S_RUN: begin
                if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
                if (marker || wd_hit) begin
                    state_d     = S_CHECK;
                    timeout_d   = !marker;  // marker wins a tie with the watchdog
                    num_d       = bus.golden_num;
                    idx_d       = '0;
                    dm_req_d    = (bus.golden_num != '0);
                    dm_addr_d   = TEST_START;
                    gold_addr_d = '0;
                end
            end
            S_CHECK: begin
                if (num_q == '0) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end else if (idx_q == num_q - 1'b1) begin
                    state_d  = S_DRAIN;
                    dm_req_d = 1'b0;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    dm_req_d    = 1'b1;
                    dm_addr_d   = TEST_START + ADDR_W'(idx_d);
                    gold_addr_d = idx_d;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                finish  = 1'b1;
            end
            default: ;
        endcase

        // Verdict uses the count including the compare landing this cycle.
        if (finish) begin
            done_d = 1'b1;
            if (timeout_q) err_cnt_d = num_q;
            pass_d = !timeout_q && (err_cnt_d == '0);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_RUN;
            num_q           <= '0;
            idx_q           <= '0;
            cmp_idx_q       <= '0;
            cmp_vld_q       <= 1'b0;
            dm_req_q        <= 1'b0;
            dm_addr_q       <= TEST_START;
            gold_addr_q     <= '0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            timeout_q       <= 1'b0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '1;
            cycle_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            num_q           <= num_d;
            idx_q           <= idx_d;
            cmp_idx_q       <= cmp_idx_d;
            cmp_vld_q       <= cmp_vld_d;
            dm_req_q        <= dm_req_d;
            dm_addr_q       <= dm_addr_d;
            gold_addr_q     <= gold_addr_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            timeout_q       <= timeout_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            cycle_cnt_q     <= cycle_cnt_d;
        end
    end

    assign bus.dm_req        = dm_req_q;
    assign bus.gold_req      = dm_req_q;
    assign bus.dm_addr       = dm_addr_q;
    assign bus.gold_addr     = gold_addr_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_err_idx_q;
    assign bus.cycle_cnt     = cycle_cnt_q;
endmodule

// File: tb/tb_dm_result_checker.sv
// Scoreboard bench for dm_result_checker: randomized result regions, decoy
// snoop writes, watchdog and reset-abort scenarios against a behavioural model.
module tb_dm_result_checker;
    localparam int          MAXC = 200;
    localparam int          TS   = 'h2000;
    localparam logic [13:0] EA   = 14'h3fff;

    typedef struct {
        int done_cyc;
        int pass;
        int to;
        int err;
        int fidx;
        int ccnt;
        int nreq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_result_checker_if #(.ADDR_W(14), .DATA_W(32), .NUM_W(7), .CYC_W(32)) bus ();

    dm_result_checker #(
        .ADDR_W(14), .DATA_W(32), .TEST_START(14'h2000), .END_ADDR(14'h3fff),
        .END_CODE(32'hFFFF_FFFF), .NUM_W(7), .MAX_CYCLES(MAXC), .CYC_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] dm_mem   [0:16383];
    logic [31:0] gold_mem [0:127];
    exp_t        q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rel = 0;
    int          seen = 0;
    int          nreq = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: one-cycle read latency on both ports.
    always @(posedge clk) begin
        if (bus.dm_req)   bus.dm_rdata   <= dm_mem[bus.dm_addr];
        if (bus.gold_req) bus.gold_rdata <= gold_mem[bus.gold_addr];
    end

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected verdict straight from the rules: count and locate mismatches
    // over the result region; timeout forces the count to num.
    function automatic exp_t model(int num, bit to, int mk);
        exp_t e;
        int nerr = 0;
        int first = 127;
        for (int i = 0; i < num; i++)
            if (dm_mem[TS + i] !== gold_mem[i]) begin
                nerr++;
                if (first == 127) first = i;
            end
        e.to       = to;
        e.err      = to ? num : nerr;
        e.fidx     = first;
        e.pass     = (!to && nerr == 0) ? 1 : 0;
        e.done_cyc = mk + num + 1;
        e.ccnt     = mk - rel;
        e.nreq     = num;
        return e;
    endfunction

    // Monitor: checks every read issue and scores each verdict when done rises.
    always @(negedge clk) begin
        if (!rst) begin
            seen = 0;
            nreq = 0;
        end else begin
            if (bus.dm_req || bus.gold_req) begin
                chk("gold_req_eq_dm_req", bus.gold_req, bus.dm_req);
                chk("gold_addr", bus.gold_addr, nreq);
                chk("dm_addr", bus.dm_addr, TS + nreq);
                nreq++;
            end
            if (bus.done && seen == 0) begin
                exp_t e;
                seen = 1;
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("pass", bus.pass, e.pass);
                    chk("timeout", bus.timeout, e.to);
                    chk("err_cnt", bus.err_cnt, e.err);
                    chk("first_err_idx", bus.first_err_idx, e.fidx);
                    chk("cycle_cnt", bus.cycle_cnt, e.ccnt);
                    chk("num_reads", nreq, e.nreq);
                end
            end
        end
    end

    task automatic drive(int t);
        bus.snoop_we    = 4'hF;
        bus.snoop_addr  = EA;
        bus.snoop_wdata = 32'hFFFF_FFFF;
        case (t)
            0: begin bus.snoop_we = 4'b0001; bus.snoop_wdata = 32'h0000_00FF; end
            1: bus.snoop_wdata = 32'h0;
            2: bus.snoop_addr = 14'($urandom_range(32'h3ffe, 0));
            3: bus.snoop_we = 4'b1110;
            4: ;
            default: begin
                bus.snoop_we    = 4'h0;
                bus.snoop_addr  = 14'($urandom);
                bus.snoop_wdata = $urandom;
            end
        endcase
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_pass"}, bus.pass, 0);
        chk({tag, "_timeout"}, bus.timeout, 0);
        chk({tag, "_err_cnt"}, bus.err_cnt, 0);
        chk({tag, "_first_err_idx"}, bus.first_err_idx, 127);
        chk({tag, "_cycle_cnt"}, bus.cycle_cnt, 0);
        chk({tag, "_dm_req"}, bus.dm_req, 0);
        chk({tag, "_gold_req"}, bus.gold_req, 0);
        chk({tag, "_dm_addr"}, bus.dm_addr, TS);
        chk({tag, "_gold_addr"}, bus.gold_addr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(5);
        bus.golden_num = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rel = cyc;
    endtask

    task automatic fill(int num, int mask, int nrand);
        for (int i = 0; i < num; i++) begin
            gold_mem[i]    = $urandom;
            dm_mem[TS + i] = gold_mem[i];
        end
        for (int i = 0; i < num && i < 32; i++)
            if (mask[i]) dm_mem[TS + i] = gold_mem[i] + 32'd1;
        if (num > 0)
            for (int j = 0; j < nrand; j++) begin
                int p = int'($urandom_range(num - 1, 0));
                dm_mem[TS + p] = gold_mem[p] ^ 32'h8000_0001;
            end
    endtask

    // delay<0: no marker (watchdog). dmode: 0 idle, 1 random decoys,
    // 2 byte-write then zero-write decoys right before the marker.
    task automatic run_test(int num, int mask, int nrand, int delay, int dmode);
        exp_t e;
        int lim, mk, w;
        do_reset();
        bus.golden_num = 7'(num);
        fill(num, mask, nrand);
        lim = (delay < 0) ? MAXC + 1 : delay;
        for (int k = 1; k < lim; k++) begin
            if (dmode == 2 && k == lim - 2) drive(0);
            else if (dmode == 2 && k == lim - 1) drive(1);
            else if (dmode == 1 && $urandom_range(3, 0) == 0) drive(int'($urandom_range(3, 0)));
            else drive(5);
            @(negedge clk);
        end
        if (delay >= 0) begin
            drive(4);
            mk = cyc + 1;
        end else mk = rel + MAXC;
        e = model(num, delay < 0, mk);
        q.push_back(e);
        @(negedge clk);
        drive(5);
        w = 0;
        while (!bus.done && w < 400) begin
            drive(int'($urandom_range(5, 0)));
            @(negedge clk);
            w++;
        end
        if (!bus.done) begin
            chk("done_wait", 0, 1);
            q.delete();
        end
        repeat (3) @(negedge clk);
        chk("done_sticky", bus.done, 1);
    endtask

    initial begin
        drive(5);
        bus.golden_num = '0;
        do_reset();
        check_reset_vals("rst");

        run_test(4, 0, 0, 50, 0);            // clean region
        run_test(4, 32'h4, 0, 50, 0);        // idx 2 off by one
        run_test(4, 32'hA, 0, 50, 0);        // idx 1 and 3
        run_test(6, 0, 1, -1, 1);            // watchdog
        run_test(3, 0, 0, 40, 2);            // partial-byte and zero decoys
        run_test(0, 0, 0, 30, 1);            // empty golden set
        run_test(0, 0, 0, -1, 0);            // empty set under timeout
        run_test(5, 0, 0, MAXC, 1);          // marker ties watchdog

        // Reset in the middle of CHECK.
        do_reset();
        bus.golden_num = 7'd10;
        fill(10, 32'h1, 0);
        for (int k = 1; k < 20; k++) begin drive(5); @(negedge clk); end
        drive(4);
        @(negedge clk);
        drive(5);
        repeat (2) @(negedge clk);
        chk("mid_err_cnt", bus.err_cnt, 1);
        chk("mid_dm_req", bus.dm_req, 1);
        chk("mid_cycle_cnt", bus.cycle_cnt, 20);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_vals("abort");
        @(negedge clk);
        rst = 1'b1;

        run_test(5, 0, 2, 25, 1);
        for (int t = 0; t < 10; t++) begin
            int d = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(150, 3));
            run_test(int'($urandom_range(20, 0)), 0, int'($urandom_range(3, 0)), d, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_time_limit: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
